// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding, default geometry and the access-legality check.
package dmem_pkg;

    localparam int DEPTH_WORDS_DEF = 256;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Request fields kept across WAIT; the word index lives beside it because
    // its width depends on DEPTH_WORDS.
    typedef struct packed {
        logic       write;
        logic [1:0] lane;
        logic [1:0] size;
        logic       uns;
        logic       err;
    } dmem_cap_t;

    // Misaligned, out-of-range or illegal-size access.
    function automatic logic access_error(input logic [31:0] addr,
                                          input logic [1:0]  size,
                                          input logic [32:0] limit);
        logic err;
        err = 1'b0;
        case (size)
            SIZE_HALF: err = addr[0];
            SIZE_WORD: err = |addr[1:0];
            SIZE_ILL:  err = 1'b1;
            default:   err = 1'b0;
        endcase
        if ({1'b0, addr} >= limit) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load lane
// select with zero/sign extension. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_lane,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    // Store side: replicate the right-aligned data onto every lane and
    // enable only the lanes the access covers.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_size)
            SIZE_BYTE: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            SIZE_WORD: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = st_data;
            end
        endcase
    end

    assign ld_shift = ld_word >> {ld_lane, 3'b000};

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_data = 32'h0;
        case (ld_size)
            SIZE_BYTE: ld_data = ld_uns ? {24'h0, ld_shift[7:0]}
                                        : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SIZE_HALF: ld_data = ld_uns ? {16'h0, ld_shift[15:0]}
                                        : {{16{ld_shift[15]}}, ld_shift[15:0]};
            SIZE_WORD: ld_data = ld_word;
            default:   ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte/half/word access.
// Optional wait states: define DMEM_WAIT_EN to insert WAIT_CYCLES cycles
// between acceptance and response; undefined gives fixed 1-cycle latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [1:0]       state;
    dmem_cap_t        cap;
    logic [IDX_W-1:0] cap_idx;

    logic             accept;
    logic             req_err;
    logic             enter_resp;
    logic [IDX_W-1:0] st_idx;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;

    logic [IDX_W-1:0] ld_idx;
    logic [1:0]       ld_lane;
    logic [1:0]       ld_size;
    logic             ld_uns;
    logic             ld_write;
    logic             ld_err;
    logic [31:0]      ld_word;
    logic [31:0]      ld_data;

    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign req_err   = access_error(req_addr, req_size, LIMIT);
    assign rsp_valid = (state == ST_RESP);
    assign st_idx    = req_addr[IDX_W+1:2];

    // Without wait states the response is built from the live request on the
    // acceptance edge; after that only the captured copy is trusted.
    always_comb begin
        ld_idx   = cap_idx;
        ld_lane  = cap.lane;
        ld_size  = cap.size;
        ld_uns   = cap.uns;
        ld_write = cap.write;
        ld_err   = cap.err;
        if (state == ST_IDLE) begin
            ld_idx   = req_addr[IDX_W+1:2];
            ld_lane  = req_addr[1:0];
            ld_size  = req_size;
            ld_uns   = req_unsigned;
            ld_write = req_write;
            ld_err   = req_err;
        end
    end

    // Errored accesses never index the array, so a non-power-of-two depth
    // cannot read past the end.
    assign ld_word = ld_err ? 32'h0 : mem[ld_idx];

    dmem_lane_align u_align (
        .st_lane  (req_addr[1:0]),
        .st_size  (req_size),
        .st_data  (req_wdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_lane  (ld_lane),
        .ld_size  (ld_size),
        .ld_uns   (ld_uns),
        .ld_word  (ld_word),
        .ld_data  (ld_data)
    );

    // Stores commit on the acceptance edge; storage is never reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[st_idx][8*i +: 8] <= st_wdata[8*i +: 8];
            end
        end
    end

    // Capture the request so later req_* activity cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap     <= '0;
            cap_idx <= '0;
        end else if (accept) begin
            cap.write <= req_write;
            cap.lane  <= req_addr[1:0];
            cap.size  <= req_size;
            cap.uns   <= req_unsigned;
            cap.err   <= req_err;
            cap_idx   <= req_addr[IDX_W+1:2];
        end
    end

`ifdef DMEM_WAIT_EN
    localparam bit               USE_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    assign enter_resp = (accept && !USE_WAIT) ||
                        ((state == ST_WAIT) && (wait_cnt == CNT_W'(1)));

    // IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP -> IDLE on rsp_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    if (USE_WAIT) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CNT_W'(1)) state <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign enter_resp = accept;

    // IDLE -> RESP on acceptance, RESP -> IDLE on rsp_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= ST_RESP;
                ST_RESP: if (rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

    // Response payload is loaded on the edge entering RESP and then held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
        end else if (enter_resp) begin
            rsp_error <= ld_err;
            rsp_rdata <= (ld_write || ld_err) ? 32'h0 : ld_data;
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 256, number of 32-bit words of backing storage; addresses 0 .. DEPTH_WORDS*4-1 are valid.
REQ-002 Parameter WAIT_CYCLES, 2, extra WAIT-state cycles per access; 0..15 legal; used only with DMEM_WAIT_EN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned in bits [7:0]/[15:0]/[31:0].
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 rsp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-015 rsp_error  output  1  access was misaligned, out of range or illegal size.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE with reset low.
REQ-018 IDLE->RESP on req_valid&&req_ready; with DMEM_WAIT_EN and WAIT_CYCLES>0, IDLE->WAIT instead.
REQ-019 WAIT SHALL load a down-counter with WAIT_CYCLES on entry and move to RESP when it reaches 1; WAIT occupancy is exactly WAIT_CYCLES cycles.
REQ-020 rsp_valid SHALL be 1 exactly in RESP; RESP->IDLE on rsp_ready; otherwise hold rsp_valid, rsp_rdata, rsp_error stable.
REQ-021 Minimum latency: rsp_valid rises on the cycle after acceptance (no wait); at most one request outstanding; peak throughput one access per two cycles.
REQ-022 Request fields SHALL be captured at acceptance; later changes on req_* SHALL NOT affect the in-flight access.
REQ-023 Error when: size 11; half with addr[0]=1; word with addr[1:0]!=00; addr >= DEPTH_WORDS*4.
REQ-024 Stores SHALL write only the addressed byte lanes on the acceptance edge; errored stores SHALL NOT modify memory.
REQ-025 Loads SHALL read the addressed word on the edge entering RESP, select the lane by addr[1:0], and extend per req_unsigned; errored loads return 0.
REQ-026 A store followed by a load to the same address SHALL return the stored value.
REQ-027 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-028 While reset is high: state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_error 0.
REQ-029 Reset during WAIT or RESP SHALL drop the pending response without re-issue; a store already committed stays committed.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro DMEM_WAIT_EN defined: WAIT state and counter present, latency 1+WAIT_CYCLES cycles.
REQ-032 Macro DMEM_WAIT_EN undefined: no WAIT state or counter logic, WAIT_CYCLES ignored, latency fixed at 1 cycle.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the size encodings, FSM state encoding and default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-034 Byte-lane steering (store byte-enable and data replication, load lane select and extension) SHALL live in sub-module dmem_lane_align.

Verification
REQ-035 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata 0xDEADBEEF, rsp_error 0.
REQ-036 Then load byte signed @0x13 -> 0xFFFFFFDE; load half unsigned @0x12 -> 0x0000DEAD.
REQ-037 Store byte 0x55 @0x11, load word @0x10 -> 0xDEAD55EF.
REQ-038 Load word @0x02, store half @0x01, load word @0x400 (DEPTH_WORDS=256), any access with size 11 -> rsp_error 1, rsp_rdata 0, memory unchanged.
REQ-039 DMEM_WAIT_EN, WAIT_CYCLES=2, rsp_ready held 0 for 3 cycles -> rsp_valid rises 3 cycles after acceptance and holds stable until rsp_ready; req_ready 0 throughout.
REQ-040 Reset asserted while in WAIT -> next cycle rsp_valid 0, req_ready 1 after reset deasserts; a new load completes normally.
